// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scanner with guard interval and tear-free frame updates.
// Optional digit blinking is built when SEVENSEG_BLINK_EN is defined.
module sevenseg_scan #(
    parameter int DIGITS       = 6,
    parameter int SCAN_DIV     = 1000,
    parameter int GUARD        = 2,
    parameter int ACTIVE_LOW   = 0,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an_out,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic                     run;
    logic [CW-1:0]            cnt, cnt_n;
    logic [IW-1:0]            idx, idx_n;
    logic [DIGITS-1:0][3:0]   disp_d, pend_d, disp_d_n;
    logic [DIGITS-1:0]        disp_dp, pend_dp, disp_dp_n;
    logic                     tick, wrap, guard_done, blink_dark, dark;
    logic [3:0]               nib;
    logic [6:0]               seg_n;
    logic                     dp_n;
    logic [DIGITS-1:0]        an_n;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1011111;
            4'd1:    s = 7'b0000011;
            4'd2:    s = 7'b1110110;
            4'd3:    s = 7'b1110011;
            4'd4:    s = 7'b0101011;
            4'd5:    s = 7'b1111001;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b1000011;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // The first edge after reset only starts the scan at cnt=0 of digit 0.
    assign tick  = run && (cnt == CNT_LAST);
    assign wrap  = tick && (idx == IDX_LAST);
    assign cnt_n = (!run || tick) ? '0 : cnt + CW'(1);
    assign idx_n = !tick ? idx : (wrap ? '0 : idx + IW'(1));
    assign guard_done = 32'(cnt_n) >= GUARD;

`ifdef SEVENSEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] fcnt;
    logic          blink_off, blink_off_n, f_end;

    assign f_end       = wrap && (fcnt == F_LAST);
    assign blink_off_n = f_end ? ~blink_off : blink_off;
    assign blink_dark  = blink_off_n & blink_mask[idx_n];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt      <= '0;
            blink_off <= 1'b0;
        end else begin
            if (wrap) fcnt <= f_end ? '0 : fcnt + FW'(1);
            blink_off <= blink_off_n;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask ^ (BLINK_FRAMES != 0);
    assign blink_dark   = 1'b0;
`endif

    always_comb begin
        disp_d_n  = disp_d;
        disp_dp_n = disp_dp;
        if (wrap && load) begin
            disp_d_n  = digits_in;
            disp_dp_n = dp_in;
        end else if (wrap && pending) begin
            disp_d_n  = pend_d;
            disp_dp_n = pend_dp;
        end
        nib   = disp_d_n[idx_n];
        dark  = blank_mask[idx_n] | blink_dark;
        seg_n = dark ? 7'b0000000 : decode(nib);
        dp_n  = disp_dp_n[idx_n] & ~dark;
        an_n  = '0;
        if (guard_done) an_n[idx_n] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            disp_d     <= '0;
            disp_dp    <= '0;
            pend_d     <= '0;
            pend_dp    <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            seg_out    <= {7{POL}};
            dp_out     <= POL;
            an_out     <= {DIGITS{POL}};
        end else begin
            run        <= 1'b1;
            cnt        <= cnt_n;
            idx        <= idx_n;
            disp_d     <= disp_d_n;
            disp_dp    <= disp_dp_n;
            frame_done <= wrap;
            seg_out    <= seg_n ^ {7{POL}};
            dp_out     <= dp_n ^ POL;
            an_out     <= an_n ^ {DIGITS{POL}};
            if (load && !wrap) begin
                pend_d  <= digits_in;
                pend_dp <= dp_in;
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan (DIGITS=4, SCAN_DIV=8, GUARD=1, BLINK_FRAMES=2).
// A second instance with ACTIVE_LOW=1 must always drive the inverted outputs.
module tb_sevenseg_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [6:0]  seg_out, seg_al;
    logic        dp_out, dp_al;
    logic [3:0]  an_out, an_al;
    logic        pending, pending_al;
    logic        frame_done, frame_done_al;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    localparam logic [6:0] S0 = 7'b1011111;
    localparam logic [6:0] S1 = 7'b0000011;
    localparam logic [6:0] S2 = 7'b1110110;
    localparam logic [6:0] S3 = 7'b1110011;
    localparam logic [6:0] S4 = 7'b0101011;
    localparam logic [6:0] S5 = 7'b1111001;
    localparam logic [6:0] S7 = 7'b1000011;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1101011;
    localparam logic [6:0] SX = 7'b0000000;

    always #5 clk = ~clk;

    sevenseg_scan #(
        .DIGITS(4), .SCAN_DIV(8), .GUARD(1),
        .ACTIVE_LOW(0), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .digits_in(digits_in), .dp_in(dp_in),
        .blank_mask(blank_mask), .blink_mask(blink_mask),
        .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out),
        .pending(pending), .frame_done(frame_done)
    );

    sevenseg_scan #(
        .DIGITS(4), .SCAN_DIV(8), .GUARD(1),
        .ACTIVE_LOW(1), .BLINK_FRAMES(2)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .load(load),
        .digits_in(digits_in), .dp_in(dp_in),
        .blank_mask(blank_mask), .blink_mask(blink_mask),
        .seg_out(seg_al), .dp_out(dp_al), .an_out(an_al),
        .pending(pending_al), .frame_done(frame_done_al)
    );

    // Edges since reset release; state at cyc=n is t=n-1 of the scan.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cyc=%0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    logic [6:0] inv_seg;
    logic [3:0] inv_an;
    logic       inv_dp, exp_fd;

    always @(negedge clk) begin
        exp_fd  = rst_n && (cyc > 1) && ((cyc - 1) % 32 == 0);
        inv_seg = ~seg_out;
        inv_an  = ~an_out;
        inv_dp  = ~dp_out;
        chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
        chk("al_seg", {25'd0, seg_al}, {25'd0, inv_seg});
        chk("al_an", {28'd0, an_al}, {28'd0, inv_an});
        chk("al_dp", {31'd0, dp_al}, {31'd0, inv_dp});
    end

    task automatic at(input int f, input int i, input int c);
        int t;
        t = 32 * f + 8 * i + c + 1;
        while (cyc < t) @(negedge clk);
    endtask

    // Drive a one-cycle load captured by the edge that produces cyc=n.
    task automatic ld(input int n, input logic [15:0] d, input logic [3:0] p);
        while (cyc < n - 1) @(negedge clk);
        load = 1'b1;
        digits_in = d;
        dp_in = p;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic view(input string name, input logic [3:0] an,
                        input logic [6:0] seg, input logic dp);
        chk({name, "_an"}, {28'd0, an_out}, {28'd0, an});
        chk({name, "_seg"}, {25'd0, seg_out}, {25'd0, seg});
        chk({name, "_dp"}, {31'd0, dp_out}, {31'd0, dp});
    endtask

    task automatic start_seq();
        for (int k = 1; k <= 8; k++) begin
            while (cyc < k) @(negedge clk);
            chk("start_an", {28'd0, an_out},
                (k == 1) ? 32'd0 : 32'd1);
        end
    endtask

    typedef struct {
        int         f;
        int         i;
        int         c;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 0, 0, 4'b0000, S4, 1'b0};
        vecs[1] = '{1, 0, 3, 4'b0001, S4, 1'b0};
        vecs[2] = '{1, 1, 0, 4'b0000, S3, 1'b1};
        vecs[3] = '{1, 1, 7, 4'b0010, S3, 1'b1};
        vecs[4] = '{1, 2, 4, 4'b0100, S2, 1'b0};
        vecs[5] = '{1, 3, 2, 4'b1000, S1, 1'b0};

        rst_n = 1'b1;
        load = 1'b0;
        digits_in = '0;
        dp_in = '0;
        blank_mask = '0;
        blink_mask = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        view("rst", 4'b0000, SX, 1'b0);
        chk("rst_pending", {31'd0, pending}, 32'd0);
        chk("rst_al_seg", {25'd0, seg_al}, 32'h7f);
        chk("rst_al_an", {28'd0, an_al}, 32'hf);
        chk("rst_al_dp", {31'd0, dp_al}, 32'd1);
        rst_n = 1'b1;

        start_seq();
        ld(5, 16'h1234, 4'b0010);
        chk("load_pending", {31'd0, pending}, 32'd1);
        at(1, 0, 0);
        chk("bound_pending", {31'd0, pending}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            at(vecs[v].f, vecs[v].i, vecs[v].c);
            view("scan", vecs[v].an, vecs[v].seg, vecs[v].dp);
        end

        ld(76, 16'h5678, 4'b0000);
        chk("tear_pending", {31'd0, pending}, 32'd1);
        at(2, 1, 5);
        view("tear_d1", 4'b0010, S3, 1'b1);
        at(2, 2, 1);
        view("tear_d2", 4'b0100, S2, 1'b0);
        at(2, 3, 6);
        view("tear_d3", 4'b1000, S1, 1'b0);
        at(3, 0, 2);
        chk("tear_cleared", {31'd0, pending}, 32'd0);
        view("new_d0", 4'b0001, S8, 1'b0);
        at(3, 1, 2);
        view("new_d1", 4'b0010, S7, 1'b0);

        ld(113, 16'h1111, 4'b0000);
        chk("coll_pend", {31'd0, pending}, 32'd1);
        at(3, 3, 1);
        view("new_d3", 4'b1000, S5, 1'b0);
        ld(129, 16'h9999, 4'b1111);
        chk("coll_pending", {31'd0, pending}, 32'd0);
        view("coll_d0", 4'b0000, S9, 1'b1);
        at(4, 3, 4);
        view("coll_d3", 4'b1000, S9, 1'b1);
        at(5, 1, 2);
        view("coll_keep", 4'b0010, S9, 1'b1);

        blank_mask = 4'b0001;
        ld(166, 16'h0A00, 4'b0101);
        at(6, 0, 2);
        view("blank_d0", 4'b0001, SX, 1'b0);
        blank_mask = 4'b0000;
        at(6, 0, 3);
        view("unblank_d0", 4'b0001, S0, 1'b1);
        at(6, 1, 2);
        view("blank_d1", 4'b0010, S0, 1'b0);
        at(6, 2, 2);
        view("hex_d2", 4'b0100, SX, 1'b1);

        at(6, 3, 7);
        blink_mask = 4'b0001;
`ifdef SEVENSEG_BLINK_EN
        at(7, 0, 4);
        view("blink_f7", 4'b0001, SX, 1'b0);
        at(8, 0, 4);
        view("blink_f8", 4'b0001, S0, 1'b1);
        at(9, 0, 4);
        view("blink_f9", 4'b0001, S0, 1'b1);
        at(10, 0, 4);
        view("blink_f10", 4'b0001, SX, 1'b0);
`else
        at(7, 0, 4);
        view("noblink_f7", 4'b0001, S0, 1'b1);
        at(8, 0, 4);
        view("noblink_f8", 4'b0001, S0, 1'b1);
        at(10, 0, 4);
        view("noblink_f10", 4'b0001, S0, 1'b1);
`endif
        at(10, 1, 4);
        view("blink_other", 4'b0010, S0, 1'b0);

        ld(361, 16'h4321, 4'b1111);
        chk("mid_pending", {31'd0, pending}, 32'd1);
        at(11, 2, 5);
        view("pre_rst", 4'b0100, SX, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        view("async_rst", 4'b0000, SX, 1'b0);
        chk("async_pending", {31'd0, pending}, 32'd0);
        chk("async_al_an", {28'd0, an_al}, 32'hf);
        chk("async_al_seg", {25'd0, seg_al}, 32'h7f);
        blink_mask = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        start_seq();
        at(0, 1, 3);
        view("post_rst_d1", 4'b0010, S0, 1'b0);
        at(1, 0, 3);
        view("discard_d0", 4'b0001, S0, 1'b0);
        chk("discard_pending", {31'd0, pending}, 32'd0);
        at(1, 2, 3);
        view("discard_d2", 4'b0100, S0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Parametrised, time-multiplexed seven-segment display driver for the real-time clock display (hh:mm:ss and similar). It holds DIGITS BCD nibbles plus per-digit decimal points and scans them onto one shared segment bus with one-hot digit enables. Each digit period starts with an anti-ghosting guard interval. New data is applied tear-free at frame boundaries. Optional blinking of selected digits supports time-setting mode.

## Interface
- DIGITS, 6, number of multiplexed digits; legal range 1..8.
- SCAN_DIV, 1000, clock cycles per digit period; must be ≥ GUARD+1.
- GUARD, 2, cycles at the start of each digit period with all enables off; legal range ≥ 0.
- ACTIVE_LOW, 0, when 1, inverts seg_out, dp_out and an_out, including their reset values.
- BLINK_FRAMES, 64, frames per blink half-period; used only with SEVENSEG_BLINK_EN.

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  single-cycle strobe that captures digits_in and dp_in
- digits_in  in  4*DIGITS  BCD nibbles; nibble k drives digit k, and digit 0 is nibbles [3:0]
- dp_in  in  DIGITS  decimal point per digit
- blank_mask  in  DIGITS  1 forces that digit dark (segments and dp off); sampled live
- blink_mask  in  DIGITS  1 makes that digit blink; sampled live
- seg_out  out  7  segment drive, registered
- dp_out  out  1  decimal-point drive, registered
- an_out  out  DIGITS  one-hot digit enable, registered
- pending  out  1  captured data is waiting for the next frame boundary
- frame_done  out  1  one-cycle pulse on the cycle after the last digit period of a frame ends

## Operation
- Decode (polarities shown for ACTIVE_LOW=0):
  - 0→1011111, 1→0000011, 2→1110110, 3→1110011, 4→0101011
  - 5→1111001, 6→1111101, 7→1000011, 8→1111111, 9→1101011
  - 10–15→0000000 (blank)
- Prescaler cnt counts 0..SCAN_DIV-1. At its terminal count, digit index idx advances. idx wraps from DIGITS-1 to 0; this wrap edge is the frame boundary.
- Data path: two register sets, pending (pend_d, pend_dp) and display (disp_d, disp_dp).
  - A load on a non-boundary edge writes pending and sets pending=1. A later load overwrites it (newest wins).
  - At a frame boundary with pending=1: display ← pending registers, then pending=0.
  - A load coinciding with a boundary edge writes digits_in and dp_in directly to display and clears pending.
- Digit blanking: a digit is dark if blank_mask[idx]=1, if its nibble is >9 (segments only; dp still follows disp_dp), or if it is blink-suppressed.
- Reset state:
  - cnt=0, idx=0, display and pending registers all zero, pending=0, frame_done=0.
  - seg_out=0, dp_out=0, an_out=0 (all ones if ACTIVE_LOW=1).
  - Reset is asynchronous and takes effect mid-frame. Pending data is discarded.

## Timing
- Outputs are registered from next-state values. While cnt=c and idx=i:
  - an_out = onehot(i) if c ≥ GUARD, otherwise 0.
  - seg_out and dp_out hold digit i's decode for the whole period, including the guard.
- After rst_n deasserts, the first rising edge starts cnt=0 of digit 0.
- Frame length is DIGITS×SCAN_DIV cycles. frame_done is high for exactly 1 cycle per frame.
- load-to-visible latency: at most one frame, plus the remainder of the current frame.
- blank_mask and blink_mask take effect on the next clock edge. No waiting for a frame boundary.

## Configuration
- SEVENSEG_BLINK_EN defined:
  - A frame counter toggles blink phase every BLINK_FRAMES frames, evaluated at frame boundaries. Phase resets to "on".
  - During the "off" phase, digits with blink_mask set are dark; their anode still scans.
- SEVENSEG_BLINK_EN undefined:
  - No frame counter and no phase logic. The blink_mask port remains but is ignored.
  - BLINK_FRAMES is unused.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=8, GUARD=1 unless stated otherwise.
- Reset: pulse rst_n low at cnt=5 of digit 2 -> seg_out, dp_out and an_out go 0 without waiting for a clock edge. After release, an_out=0000 for 1 cycle, then 0001 for 7 cycles.
- Scan/decode: load 16'h1234 with dp_in=4'b0010, then wait one boundary -> an_out=0001 shows seg 0101011 with dp 0; an_out=0010 shows 1110011 with dp 1; digits 2 and 3 show 1110110 and 0000011. frame_done pulses every 32 cycles.
- Tear-free update: load 16'h5678 at idx=1 -> pending=1, and digits 1–3 keep their old values. After the boundary, pending=0 and digit 0 shows 1111111.
- Boundary collision: assert load 16'h9999 on the wrap edge while pend holds 16'h1111 -> the display shows 9 (1101011) on all digits and pending=0.
- Blank: load 16'h0A00 and set blank_mask=0001 -> digit 0 seg=0000000 and dp=0; digit 2 seg=0000000; digit 1 seg=1011111.
- Blink (macro defined, BLINK_FRAMES=2, blink_mask=0001) -> digit 0 is lit in frames 0–1, dark in frames 2–3, lit in frames 4–5. With the macro undefined, digit 0 is always lit. Repeat the reset check with ACTIVE_LOW=1 -> outputs reset to all ones.
